hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS datapath. Consumes hit/miss status from the icache/dcache and dependency information from the ID/EX/MEM stages, and drives the per-latch enables, bubble-insert flushes and PC enable. Forwarding select remains with the hazard unit. This block decides only when stages advance, freeze or are squashed, and when the core is halted.

---
 rtl/hazard_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Status/enable bundle between the pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_if #(
    parameter int REGW = 5
);
    logic            ihit;
    logic            dhit;
    logic            dmem_req;
    logic            EX_memread;
    logic [REGW-1:0] EX_wsel;
    logic [REGW-1:0] ID_rs;
    logic [REGW-1:0] ID_rt;
    logic            ID_rt_used;
    logic            EX_branch_taken;
    logic            MEM_halt;
    logic            pc_en;
    logic            ifid_en;
    logic            idex_en;
    logic            exmem_en;
    logic            memwb_en;
    logic            ifid_flush;
    logic            idex_flush;
    logic            halted;
    logic [1:0]      state;

    modport master (
        output ihit, dhit, dmem_req, EX_memread, EX_wsel, ID_rs, ID_rt,
               ID_rt_used, EX_branch_taken, MEM_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, state
    );

    modport slave (
        input  ihit, dhit, dmem_req, EX_memread, EX_wsel, ID_rs, ID_rt,
               ID_rt_used, EX_branch_taken, MEM_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing: stage enables, bubble flushes, PC enable and halt.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REGW = 5
) (
    input  logic        CLK,
    input  logic        nRST,
    hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [15:0] lu_count
`endif
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam logic [REGW-1:0] ZERO_REG = '0;

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   halted;
    logic   lu;
    logic   dmiss;
    logic   advance;

    assign lu = hz.EX_memread && (hz.EX_wsel != ZERO_REG) &&
                ((hz.EX_wsel == hz.ID_rs) || (hz.ID_rt_used && (hz.EX_wsel == hz.ID_rt)));
    assign dmiss = hz.dmem_req && !hz.dhit;

    // Cycles in which the normal branch / load-use / fetch rules decide the enables.
    assign advance = ((state_q == RUN) && !hz.MEM_halt && !dmiss) ||
                     ((state_q == DWAIT) && hz.dhit);

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!nRST) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaulting every comb output first guarantees no latch on untaken branches.
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (hz.MEM_halt) state_d = DRAIN;
                else if (dmiss)  state_d = DWAIT;
            end
            DWAIT:   if (hz.dhit) state_d = RUN;
            DRAIN:   state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctrl   = '0;
        halted = 1'b0;
        if (nRST) begin
            halted = (state_q == HALTED);
            if ((state_q == RUN) && hz.MEM_halt) begin
                ctrl.memwb_en = 1'b1;
            end else if (advance) begin
                if (hz.EX_branch_taken) begin
                    ctrl = '1;
                end else if (lu) begin
                    ctrl.idex_en    = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    ctrl.exmem_en   = 1'b1;
                    ctrl.memwb_en   = 1'b1;
                end else if (!hz.ihit) begin
                    ctrl            = '1;
                    ctrl.pc_en      = 1'b0;
                    ctrl.idex_flush = 1'b0;
                end else begin
                    ctrl            = '1;
                    ctrl.ifid_flush = 1'b0;
                    ctrl.idex_flush = 1'b0;
                end
            end
        end
    end

    assign hz.pc_en      = ctrl.pc_en;
    assign hz.ifid_en    = ctrl.ifid_en;
    assign hz.idex_en    = ctrl.idex_en;
    assign hz.exmem_en   = ctrl.exmem_en;
    assign hz.memwb_en   = ctrl.memwb_en;
    assign hz.ifid_flush = ctrl.ifid_flush;
    assign hz.idex_flush = ctrl.idex_flush;
    assign hz.halted     = halted;
    assign hz.state      = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic [15:0] lucnt_q, lucnt_d;
    logic        rule_branch;
    logic        rule_lu;

    assign rule_branch = nRST && advance && hz.EX_branch_taken;
    assign rule_lu     = nRST && advance && !hz.EX_branch_taken && lu;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        lucnt_d = lucnt_q;
        if (nRST && (state_q != HALTED) && !ctrl.pc_en && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (rule_branch && (flush_q != '1)) flush_d = flush_q + 16'd1;
        if (rule_lu && (lucnt_q != '1))     lucnt_d = lucnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
            lucnt_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            lucnt_q <= lucnt_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign lu_count     = lucnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic against a flag-based model.
module tb_hazard_ctrl;
    localparam int REGW = 5;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    hazard_if #(.REGW(REGW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic [15:0] lu_count;
`endif

    hazard_ctrl #(.REGW(REGW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .lu_count     (lu_count)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: the pipeline is either flowing, waiting on the dcache, draining a HALT, or halted.
    bit      m_valid  = 1'b0;
    bit      m_wait   = 1'b0;
    bit      m_drain  = 1'b0;
    bit      m_halted = 1'b0;
    longint  m_stall  = 0;
    longint  m_flush  = 0;
    longint  m_lu     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    task automatic idle();
        hz.ihit = 1'b1; hz.dhit = 1'b0; hz.dmem_req = 1'b0; hz.EX_memread = 1'b0;
        hz.EX_wsel = '0; hz.ID_rs = '0; hz.ID_rt = '0; hz.ID_rt_used = 1'b0;
        hz.EX_branch_taken = 1'b0; hz.MEM_halt = 1'b0;
    endtask

    // One clock: check outputs at the negedge against the model, then advance model and clock.
    task automatic cycle();
        logic [6:0] e;
        logic [1:0] exp_state;
        bit lu_h, exp_halted, frozen;
        @(negedge CLK);
        lu_h = hz.EX_memread && (int'(hz.EX_wsel) != 0) &&
               ((int'(hz.EX_wsel) == int'(hz.ID_rs)) ||
                (hz.ID_rt_used && (int'(hz.EX_wsel) == int'(hz.ID_rt))));
        frozen = m_wait ? !hz.dhit : (hz.dmem_req && !hz.dhit);
        e = 7'b0;
        exp_halted = 1'b0;
        if (!nRST)                          e = 7'b0;
        else if (m_halted)                  exp_halted = 1'b1;
        else if (m_drain)                   e = 7'b0;
        else if (!m_wait && hz.MEM_halt)    e = 7'b0000100;
        else if (frozen)                    e = 7'b0;
        else if (hz.EX_branch_taken)        e = 7'b1111111;
        else if (lu_h)                      e = 7'b0011101;
        else if (!hz.ihit)                  e = 7'b0111110;
        else                                e = 7'b1111100;
        exp_state = m_halted ? 2'd3 : m_drain ? 2'd2 : m_wait ? 2'd1 : 2'd0;

        check("ctrl", {25'b0, hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                       hz.ifid_flush, hz.idex_flush}, {25'b0, e});
        check("halted", {31'b0, hz.halted}, {31'b0, exp_halted});
        if (m_valid) check("state", {30'b0, hz.state}, {30'b0, exp_state});
`ifdef HAZARD_PERF_CNT_EN
        if (m_valid) begin
            check("stall_cycles", stall_cycles, m_stall[31:0]);
            check("flush_count", {16'b0, flush_count}, {16'b0, m_flush[15:0]});
            check("lu_count", {16'b0, lu_count}, {16'b0, m_lu[15:0]});
        end
`endif

        if (!nRST) begin
            m_valid = 1'b1; m_wait = 1'b0; m_drain = 1'b0; m_halted = 1'b0;
            m_stall = 0; m_flush = 0; m_lu = 0;
        end else begin
            if (!m_halted && !e[6] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e[1] && e[0] && m_flush < 65535) m_flush++;
            if (e[0] && !e[1] && m_lu < 65535)   m_lu++;
            if (m_halted)                  m_halted = 1'b1;
            else if (m_drain)              begin m_drain = 1'b0; m_halted = 1'b1; end
            else if (m_wait)               m_wait = !hz.dhit;
            else if (hz.MEM_halt)          m_drain = 1'b1;
            else if (hz.dmem_req && !hz.dhit) m_wait = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        cycle();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        cycle();
        cycle();
        nRST = 1'b1;

        // Free-running pipeline
        repeat (3) cycle();

        // Load-use on rs, then the same with r0 as destination
        hz.EX_memread = 1'b1; hz.EX_wsel = 5'd8; hz.ID_rs = 5'd8;
        cycle();
        idle(); cycle();
        hz.EX_memread = 1'b1; hz.EX_wsel = 5'd0; hz.ID_rs = 5'd0;
        cycle();
        // Load-use through rt only when rt is read
        hz.EX_memread = 1'b1; hz.EX_wsel = 5'd9; hz.ID_rs = 5'd1; hz.ID_rt = 5'd9; hz.ID_rt_used = 1'b0;
        cycle();
        hz.ID_rt_used = 1'b1;
        cycle();
        idle();

        // Four-cycle dcache miss
        hz.dmem_req = 1'b1; hz.dhit = 1'b0;
        repeat (4) cycle();
        hz.dhit = 1'b1;
        cycle();
        idle(); cycle();

        // Taken branch with a missing fetch, then branch together with a load-use
        hz.EX_branch_taken = 1'b1; hz.ihit = 1'b0;
        cycle();
        hz.ihit = 1'b1; hz.EX_memread = 1'b1; hz.EX_wsel = 5'd3; hz.ID_rs = 5'd3;
        cycle();
        idle();
        hz.ihit = 1'b0;
        cycle();
        idle();

        // HALT reaching MEM, held halted, then reset
        hz.MEM_halt = 1'b1;
        cycle();
        idle();
        repeat (12) cycle();
        do_reset();
        cycle();

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        repeat (3) begin
            hz.EX_memread = 1'b1; hz.EX_wsel = 5'd4; hz.ID_rs = 5'd4;
            cycle();
            idle(); cycle();
        end
        hz.dmem_req = 1'b1;
        repeat (4) cycle();
        hz.dhit = 1'b1;
        cycle();
        idle(); cycle();
        check("lu_count_plan", {16'b0, lu_count}, 32'd3);
        check("stall_cycles_plan", stall_cycles, 32'd7);

        hz.EX_branch_taken = 1'b1;
        repeat (70000) cycle();
        idle(); cycle();
        check("flush_count_sat", {16'b0, flush_count}, 32'h0000_FFFF);
`endif

        // Random traffic with occasional resets, likelier once halted
        for (int i = 0; i < 4000; i++) begin
            nRST = !(($urandom_range(199) == 0) || (m_halted && ($urandom_range(7) == 0)));
            hz.ihit            = ($urandom_range(9) < 8);
            hz.dhit            = ($urandom_range(2) == 0);
            hz.dmem_req        = ($urandom_range(4) == 0);
            hz.EX_memread      = ($urandom_range(2) == 0);
            hz.EX_wsel         = REGW'($urandom_range(3));
            hz.ID_rs           = REGW'($urandom_range(3));
            hz.ID_rt           = REGW'($urandom_range(3));
            hz.ID_rt_used      = ($urandom_range(1) == 0);
            hz.EX_branch_taken = ($urandom_range(9) == 0);
            hz.MEM_halt        = ($urandom_range(59) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
